intc_apb_bridge: RTL and testbench

APB3 slave front end for the interrupt-controller register core. Converts APB setup/access transfers into the single-cycle `wr_en`/`rd_en`/`addr`/`wdata` strobes the register core consumes, and captures its combinational `rdata`. Also inserts programmable wait states and flags illegal accesses with `pslverr`. Sits directly upstream of the register core; its register-side outputs wire one-to-one to the core's register interface.

---
 rtl/intc_apb_bridge.sv | 75 +++++++
 tb/tb_intc_apb_bridge.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/intc_apb_bridge.sv
// intc_apb_bridge: APB3 slave front end that turns APB transfers into
// single-cycle register-core strobes, with programmable wait states and
// decode-error reporting on pslverr.
// Ports: clk/rst_n (async active-low); APB psel, penable, pwrite, paddr,
// pwdata, prdata, pready, pslverr; register core wr_en, rd_en, addr, wdata,
// rdata (combinational from the core, sampled while rd_en is high).
module intc_apb_bridge #(
  parameter int ADDR_W = 12,
  parameter int N      = 8,
  parameter int WAIT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              wr_en,
  output logic              rd_en,
  output logic [7:0]        addr,
  output logic [31:0]       wdata,
  input  logic [31:0]       rdata
);
  typedef enum logic [1:0] {IDLE, WAITST, ACCESS, RESP} state_t;
  localparam logic [31:0] LAST = 32'(32 + 4 * N - 4);
  state_t      state, state_nx;
  logic [2:0]  cnt;
  logic        pw, err, setup, dec_err;
  logic [31:0] pa;
  assign pa    = 32'(paddr);
  assign setup = psel && !penable;
  // Legal map: control block 0x00..0x1C plus one priority word per source.
  assign dec_err = (|pa[1:0]) || (|pa[31:8])
                || !(pa[7:0] <= 8'h1c || (pa >= 32'h20 && pa <= LAST))
                || (pwrite && (pa[7:0] == 8'h18 || pa[7:0] == 8'h1c));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = setup ? ((WAIT != 0) ? WAITST : ACCESS) : IDLE;
      WAITST:  state_nx = !psel ? IDLE : (cnt == 3'd1 ? ACCESS : WAITST);
      ACCESS:  state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  assign wr_en   = state == ACCESS && !err && pw;
  assign rd_en   = state == ACCESS && !err && !pw;
  assign pready  = state == RESP;
  assign pslverr = pready && err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      pw     <= 1'b0;
      err    <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      prdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && setup) begin
        pw    <= pwrite;
        err   <= dec_err;
        addr  <= pa[7:0];
        wdata <= pwdata;
        cnt   <= 3'(WAIT);
      end
      if (state == WAITST) cnt <= cnt - 3'd1;
      if (state == ACCESS) prdata <= err ? 32'd0 : (pw ? prdata : rdata);
    end
  end
endmodule

// File: tb/tb_intc_apb_bridge.sv
// tb_intc_apb_bridge: scoreboard bench driving a WAIT=0 and a WAIT=3 bridge.
module tb_intc_apb_bridge;
  localparam int NS = 8;
  localparam int W1 = 3;
  typedef struct {
    int          dut;
    bit          wr;
    bit          err;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] prd;
    int          scyc;
    int          rcyc;
  } item_t;
  logic        clk = 0, rst_n = 0;
  logic [1:0]  psel = 0, wr_en, rd_en, pready, pslverr;
  logic        penable = 0, pwrite = 0;
  logic [11:0] paddr = 0;
  logic [31:0] pwdata = 0;
  logic [31:0] prdata [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [7:0]  addr [2];
  logic [31:0] last [2];
  item_t       q[$];
  bit          strobed = 0;
  int          cyc = 0, errors = 0, checks = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] core_val(input logic [7:0] a);
    return (a == 8'h18) ? 32'h3 : {a, ~a, a ^ 8'h5a, a + 8'd1};
  endfunction
  assign rdata[0] = core_val(addr[0]);
  assign rdata[1] = core_val(addr[1]);
  intc_apb_bridge #(.ADDR_W(12), .N(NS), .WAIT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]));
  intc_apb_bridge #(.ADDR_W(12), .N(NS), .WAIT(W1)) u1 (
    .clk(clk), .rst_n(rst_n), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cyc %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s (cyc %0d)", n, cyc);
  endtask
  function automatic bit exp_err(input bit wr, input int p);
    bit legal;
    legal = (p <= 28) || (p >= 32 && p <= 32 + 4 * NS - 4);
    return (p % 4 != 0) || (p >= 256) || !legal || (wr && (p == 24 || p == 28));
  endfunction
  function automatic int pick();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, 24)) * 4;
    if (r == 6) return int'($urandom_range(0, 255));
    if (r == 7) return int'($urandom_range(256, 4095));
    if (r == 8) return $urandom_range(0, 1) ? 24 : 28;
    return int'($urandom_range(0, 4095));
  endfunction
  task automatic xfer(input int d, input bit wr, input int p, input logic [31:0] wd);
    item_t it;
    int w;
    w = d ? W1 : 0;
    it.dut = d; it.wr = wr; it.err = exp_err(wr, p); it.a = 8'(p); it.wd = wd;
    if (!wr || it.err) last[d] = it.err ? 32'd0 : core_val(8'(p));
    it.prd = last[d]; it.scyc = cyc + 1 + w; it.rcyc = cyc + 2 + w;
    q.push_back(it);
    psel[d] = 1; penable = 0; pwrite = wr; paddr = 12'(p); pwdata = wd;
    @(posedge clk); #1 penable = 1;
    repeat (2 + w) @(posedge clk);
    #1 psel[d] = 0; penable = 0;
  endtask
  task automatic abort(input int k);
    psel[1] = 1; penable = 0; pwrite = 1'($urandom); paddr = 12'h004; pwdata = $urandom;
    @(posedge clk); #1 penable = 1;
    repeat (k - 1) begin @(posedge clk); #1; end
    psel[1] = 0; penable = 0;
    @(posedge clk); #1;
  endtask
  always @(negedge clk) if (rst_n) for (int d = 0; d < 2; d++) begin
    if (wr_en[d] || rd_en[d]) begin
      if (q.size() == 0 || q[0].dut != d || strobed) fail($sformatf("strobe_unexpected dut%0d", d));
      else begin
        chk("strobe_kind", {30'b0, wr_en[d], rd_en[d]}, q[0].err ? 32'd0 : (q[0].wr ? 32'd2 : 32'd1));
        chk("strobe_addr", {24'b0, addr[d]}, {24'b0, q[0].a});
        if (q[0].wr) chk("strobe_wdata", wdata[d], q[0].wd);
        chk("strobe_cycle", cyc, q[0].scyc);
        strobed = 1;
      end
    end
    if (pready[d]) begin
      if (q.size() == 0 || q[0].dut != d) fail($sformatf("pready_unexpected dut%0d", d));
      else begin
        item_t it;
        it = q.pop_front();
        chk("pslverr", {31'b0, pslverr[d]}, {31'b0, it.err});
        chk("prdata", prdata[d], it.prd);
        chk("pready_cycle", cyc, it.rcyc);
        chk("strobe_seen", {31'b0, strobed}, {31'b0, !it.err});
        strobed = 0;
      end
    end else if (pslverr[d]) fail($sformatf("pslverr_without_pready dut%0d", d));
  end
  initial begin
    last[0] = 0; last[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_outs%0d", d), {prdata[d] | wdata[d]} | {24'b0, addr[d]}
          | {28'b0, pready[d], pslverr[d], wr_en[d], rd_en[d]}, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    xfer(0, 1, 'h00, 32'h000000A5);
    xfer(0, 0, 'h18, 0);
    xfer(0, 1, 'h04, 32'h12345678);
    xfer(0, 1, 'h05, 32'h1);
    xfer(0, 1, 'h18, 32'h2);
    xfer(0, 1, 'h100, 32'h3);
    xfer(0, 0, 'h40, 0);
    xfer(0, 0, 'h3C, 0);
    xfer(0, 1, 'h08, 32'hF0);
    xfer(0, 0, 'h08, 0);
    xfer(1, 0, 'h04, 0);
    abort(2);
    xfer(1, 0, 'h04, 0);
    xfer(1, 1, 'h1C, 32'h5);
    for (int i = 0; i < 60; i++) begin
      int d;
      d = int'($urandom_range(0, 1));
      if (d == 1 && $urandom_range(0, 3) == 0) abort(int'($urandom_range(1, W1)));
      else xfer(d, 1'($urandom), pick(), $urandom);
    end
    psel[0] = 1; penable = 0; pwrite = 1; paddr = 12'h004; pwdata = 32'hdeadbeef;
    @(posedge clk); #1 penable = 1;
    chk("rst_pre_wr_en", {31'b0, wr_en[0]}, 32'd1);
    rst_n = 0;
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("rst_mid_outs%0d", d), {prdata[d] | wdata[d]} | {24'b0, addr[d]}
          | {28'b0, pready[d], pslverr[d], wr_en[d], rd_en[d]}, 32'd0);
    psel[0] = 0; penable = 0; last[0] = 0; last[1] = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (6) @(posedge clk);
    #1;
    xfer(0, 0, 'h0C, 0);
    xfer(1, 0, 'h10, 0);
    repeat (4) @(posedge clk);
    #1 chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
